// File: rtl/load_unit.sv
// Load responder: issues word reads to data memory, aligns/extends the returned
// word per funct3 and queues {data, rob_ix, exc} in a credit-protected FIFO.
module load_unit #(
   parameter int unsigned ROB_IX      = 2,
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned RESP_DEPTH  = 4,
   parameter int unsigned MEM_AW      = 12
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              flush_in,
   input  logic              req_valid_in,
   input  logic [31:0]       req_addr_in,
   input  logic [ROB_IX:0]   req_rob_ix_in,
   input  logic [2:0]        req_funct3_in,
   output logic              req_read_out,
   output logic              mem_en_out,
   output logic [MEM_AW-1:0] mem_addr_out,
   input  logic [31:0]       mem_rdata_in,
   output logic              result_valid_out,
   output logic [31:0]       result_data_out,
   output logic [ROB_IX:0]   result_rob_ix_out,
   output logic              result_exc_out,
   input  logic              result_ready_in
);
   localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);

   typedef struct packed {
      logic [ROB_IX:0] rob_ix;
      logic [2:0]      funct3;
      logic [1:0]      off;
      logic            exc;
   } pipe_t;

   typedef struct packed {
      logic [31:0]     data;
      logic [ROB_IX:0] rob_ix;
      logic            exc;
   } resp_t;

   logic             pipe_vld_q [MEM_LATENCY];
   pipe_t            pipe_q     [MEM_LATENCY];
   resp_t            fifo_q     [RESP_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, credit_q;

   logic       accept, illegal, push, pop;
   pipe_t      head;
   resp_t      fmt;
   logic [7:0] byte_v;
   logic [15:0] half_v;
   logic       unused_addr_hi;

   assign unused_addr_hi = ^req_addr_in[31:MEM_AW+2];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Request legality: alignment per access size, unsupported funct3 codes
   always_comb begin
      illegal = 1'b0;
      case (req_funct3_in)
         3'd0, 3'd4: illegal = 1'b0;
         3'd1, 3'd5: illegal = req_addr_in[0];
         3'd2:       illegal = |req_addr_in[1:0];
         default:    illegal = 1'b1;
      endcase
   end

   // Accept while a response slot is guaranteed; credit is registered so no ready path
   assign accept       = rst_in & req_valid_in & ~flush_in & (credit_q < CNT_W'(RESP_DEPTH));
   assign req_read_out = accept;
   assign mem_en_out   = accept & ~illegal;
   assign mem_addr_out = rst_in ? req_addr_in[MEM_AW+1:2] : '0;

   // Tag pipe matching the memory latency; flush drops every in-flight read
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < MEM_LATENCY; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_q[i]     <= '0;
         end
      end else begin
         pipe_vld_q[0]    <= accept;
         pipe_q[0].rob_ix <= req_rob_ix_in;
         pipe_q[0].funct3 <= req_funct3_in;
         pipe_q[0].off    <= req_addr_in[1:0];
         pipe_q[0].exc    <= illegal;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_q[i]     <= pipe_q[i-1];
         end
         if (flush_in) begin
            for (int i = 0; i < MEM_LATENCY; i++) pipe_vld_q[i] <= 1'b0;
         end
      end
   end

   // Byte/half extraction and sign/zero extension at pipe exit
   always_comb begin
      head       = pipe_q[MEM_LATENCY-1];
      byte_v     = mem_rdata_in[{head.off, 3'b000} +: 8];
      half_v     = mem_rdata_in[{head.off[1], 4'b0000} +: 16];
      fmt.rob_ix = head.rob_ix;
      fmt.exc    = head.exc;
      fmt.data   = '0;
      if (!head.exc) begin
         case (head.funct3)
            3'd0:    fmt.data = {{24{byte_v[7]}}, byte_v};
            3'd1:    fmt.data = {{16{half_v[15]}}, half_v};
            3'd2:    fmt.data = mem_rdata_in;
            3'd4:    fmt.data = {24'd0, byte_v};
            3'd5:    fmt.data = {16'd0, half_v};
            default: fmt.data = '0;
         endcase
      end
   end

   assign push = pipe_vld_q[MEM_LATENCY-1] & ~flush_in;
   assign pop  = result_valid_out & result_ready_in & ~flush_in;

   // Response FIFO and outstanding-load credit
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         credit_q <= '0;
         for (int i = 0; i < RESP_DEPTH; i++) fifo_q[i] <= '0;
      end else if (flush_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         credit_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= fmt;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
         credit_q <= credit_q + CNT_W'(accept) - CNT_W'(pop);
      end
   end

   assign result_valid_out  = (count_q != '0);
   assign result_data_out   = fifo_q[rd_ptr_q].data;
   assign result_rob_ix_out = fifo_q[rd_ptr_q].rob_ix;
   assign result_exc_out    = fifo_q[rd_ptr_q].exc;

   // Credit makes a push into a full FIFO impossible
   a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
      !(push && !pop && (count_q == CNT_W'(RESP_DEPTH))));

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected responses, a monitor
// pops and compares each result the DUT hands over.
module tb_load_unit;
   localparam int unsigned ROB_IX      = 2;
   localparam int unsigned MEM_LATENCY = 2;
   localparam int unsigned RESP_DEPTH  = 4;
   localparam int unsigned MEM_AW      = 12;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              flush_in;
   logic              req_valid_in;
   logic [31:0]       req_addr_in;
   logic [ROB_IX:0]   req_rob_ix_in;
   logic [2:0]        req_funct3_in;
   logic              req_read_out;
   logic              mem_en_out;
   logic [MEM_AW-1:0] mem_addr_out;
   logic [31:0]       mem_rdata_in;
   logic              result_valid_out;
   logic [31:0]       result_data_out;
   logic [ROB_IX:0]   result_rob_ix_out;
   logic              result_exc_out;
   logic              result_ready_in;

   always #5 clk_in = ~clk_in;

   load_unit #(.ROB_IX(ROB_IX), .MEM_LATENCY(MEM_LATENCY), .RESP_DEPTH(RESP_DEPTH),
               .MEM_AW(MEM_AW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
      .req_valid_in(req_valid_in), .req_addr_in(req_addr_in),
      .req_rob_ix_in(req_rob_ix_in), .req_funct3_in(req_funct3_in),
      .req_read_out(req_read_out), .mem_en_out(mem_en_out), .mem_addr_out(mem_addr_out),
      .mem_rdata_in(mem_rdata_in), .result_valid_out(result_valid_out),
      .result_data_out(result_data_out), .result_rob_ix_out(result_rob_ix_out),
      .result_exc_out(result_exc_out), .result_ready_in(result_ready_in));

   // Data memory model with fixed read latency; junk returned when not enabled
   logic [31:0] mem_words [1 << MEM_AW];
   logic [31:0] rd_pipe   [MEM_LATENCY];
   always @(posedge clk_in) begin
      rd_pipe[0] <= mem_en_out ? mem_words[mem_addr_out] : 32'($urandom);
      for (int i = 1; i < MEM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata_in = rd_pipe[MEM_LATENCY-1];

   typedef struct {
      logic [31:0]     data;
      logic [ROB_IX:0] rob;
      logic            exc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference load semantics from the architectural rules
   function automatic exp_t model(input logic [31:0] a, input logic [2:0] f3,
                                  input logic [ROB_IX:0] rob);
      exp_t        r;
      logic [31:0] w;
      int unsigned off, b, h;
      logic        bad;
      w   = mem_words[a[MEM_AW+1:2]];
      off = int'(a[1:0]);
      b   = (w >> (8 * off)) & 32'hFF;
      h   = (w >> (16 * (off / 2))) & 32'hFFFF;
      bad = 1'b0;
      r.data = 32'd0;
      case (f3)
         3'd0: r.data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd1: begin bad = (off % 2) != 0; r.data = (h >= 32768) ? h + 32'hFFFF_0000 : h; end
         3'd2: begin bad = off != 0; r.data = w; end
         3'd4: r.data = b;
         3'd5: begin bad = (off % 2) != 0; r.data = h; end
         default: bad = 1'b1;
      endcase
      if (bad) r.data = 32'd0;
      r.exc = bad;
      r.rob = rob;
      return r;
   endfunction

   // Monitor: every handed-over result is checked against the scoreboard head
   always @(negedge clk_in) begin
      if (rst_in && !flush_in && result_valid_out && result_ready_in) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got data 0x%08h rob %0d, expected none",
                     result_data_out, result_rob_ix_out);
         end else begin
            mon_e = exp_q.pop_front();
            check("res_data", result_data_out, mon_e.data);
            check("res_rob", 32'(result_rob_ix_out), 32'(mon_e.rob));
            check("res_exc", 32'(result_exc_out), 32'(mon_e.exc));
         end
      end
   end

   // One request cycle: drive, observe acceptance, record expectation
   task automatic try_once(input logic [31:0] a, input logic [2:0] f3, input logic [ROB_IX:0] rob,
                           input logic use_lit, input logic [31:0] lit_d, input logic lit_x,
                           output logic acc);
      exp_t e;
      req_valid_in  = 1'b1;
      req_addr_in   = a;
      req_funct3_in = f3;
      req_rob_ix_in = rob;
      @(negedge clk_in);
      acc = req_read_out;
      if (acc) begin
         e = model(a, f3, rob);
         if (use_lit) begin
            e.data = lit_d;
            e.exc  = lit_x;
         end
         check("mem_en", 32'(mem_en_out), 32'(!e.exc));
         if (!e.exc) check("mem_addr", 32'(mem_addr_out), 32'(a[MEM_AW+1:2]));
         exp_q.push_back(e);
      end
      @(posedge clk_in);
      #1;
      req_valid_in = 1'b0;
   endtask

   task automatic issue(input logic [31:0] a, input logic [2:0] f3, input logic [ROB_IX:0] rob,
                        input logic use_lit, input logic [31:0] lit_d, input logic lit_x);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 30 && !acc; i++) try_once(a, f3, rob, use_lit, lit_d, lit_x, acc);
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL issue_timeout: addr 0x%08h not accepted, expected acceptance", a);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_valid_in    = 1'b0;
      result_ready_in = 1'b1;
      while ((exp_q.size() != 0 || result_valid_out) && n < 200) begin
         step();
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic flush_cycle();
      flush_in     = 1'b1;
      req_valid_in = 1'b1;
      @(negedge clk_in);
      check("flush_read_out", 32'(req_read_out), 32'd0);
      exp_q.delete();
      step();
      flush_in     = 1'b0;
      req_valid_in = 1'b0;
   endtask

   logic acc;
   int   nacc;

   initial begin
      for (int i = 0; i < (1 << MEM_AW); i++) mem_words[i] = 32'($urandom);
      rst_in          = 1'b0;
      flush_in        = 1'b0;
      req_valid_in    = 1'b1;
      req_addr_in     = 32'h104;
      req_funct3_in   = 3'd2;
      req_rob_ix_in   = '0;
      result_ready_in = 1'b1;

      // Reset holds everything off even with a request pending
      #12;
      check("rst_read_out", 32'(req_read_out), 32'd0);
      check("rst_valid", 32'(result_valid_out), 32'd0);
      check("rst_mem_en", 32'(mem_en_out), 32'd0);
      req_valid_in = 1'b0;
      step();
      rst_in = 1'b1;
      step();

      // lw with latency check: valid exactly MEM_LATENCY+1 cycles after accept
      mem_words[12'h041] = 32'hDEAD_BEEF;
      try_once(32'h104, 3'd2, 3'd3, 1'b1, 32'hDEAD_BEEF, 1'b0, acc);
      check("lw_accept", 32'(acc), 32'd1);
      @(negedge clk_in);
      check("lat_c1", 32'(result_valid_out), 32'd0);
      step();
      @(negedge clk_in);
      check("lat_c2", 32'(result_valid_out), 32'd0);
      step();
      @(negedge clk_in);
      check("lat_c3", 32'(result_valid_out), 32'd1);
      step();
      drain();

      // Sub-word formatting, then exceptions interleaved with a good neighbour
      mem_words[12'h041] = 32'h1234_80FF;
      issue(32'h105, 3'd0, 3'd1, 1'b1, 32'hFFFF_FF80, 1'b0);
      issue(32'h105, 3'd4, 3'd2, 1'b1, 32'h0000_0080, 1'b0);
      issue(32'h106, 3'd1, 3'd4, 1'b1, 32'h0000_1234, 1'b0);
      issue(32'h102, 3'd2, 3'd5, 1'b1, 32'h0000_0000, 1'b1);
      issue(32'h100, 3'd3, 3'd6, 1'b1, 32'h0000_0000, 1'b1);
      issue(32'h104, 3'd2, 3'd7, 1'b1, 32'h1234_80FF, 1'b0);
      drain();

      // Backpressure: credit limits outstanding loads to RESP_DEPTH
      result_ready_in = 1'b0;
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         try_once(32'h200 + 32'(4 * i), 3'd2, ROB_IX'(i), 1'b0, 32'd0, 1'b0, acc);
         if (acc) nacc++;
      end
      check("bp_accepted", 32'(nacc), 32'(RESP_DEPTH));
      for (int i = 0; i < 3; i++) begin
         try_once(32'h210, 3'd2, 3'd4, 1'b0, 32'd0, 1'b0, acc);
         check("bp_blocked", 32'(acc), 32'd0);
      end
      result_ready_in = 1'b1;
      try_once(32'h210, 3'd2, 3'd4, 1'b0, 32'd0, 1'b0, acc);
      check("bp_pop_cycle", 32'(acc), 32'd0);
      result_ready_in = 1'b0;
      try_once(32'h210, 3'd2, 3'd4, 1'b0, 32'd0, 1'b0, acc);
      check("bp_after_pop", 32'(acc), 32'd1);
      drain();

      // Flush with one queued result and two reads in flight
      result_ready_in = 1'b0;
      issue(32'h300, 3'd2, 3'd1, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      issue(32'h304, 3'd2, 3'd2, 1'b0, 32'd0, 1'b0);
      issue(32'h308, 3'd2, 3'd3, 1'b0, 32'd0, 1'b0);
      result_ready_in = 1'b1;
      flush_cycle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         check("post_flush_valid", 32'(result_valid_out), 32'd0);
         step();
      end
      result_ready_in = 1'b0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
         try_once(32'h400 + 32'(4 * i), 3'd2, ROB_IX'(i), 1'b0, 32'd0, 1'b0, acc);
         check("post_flush_credit", 32'(acc), 32'd1);
      end
      drain();

      // Randomized traffic with random backpressure and occasional flush
      for (int i = 0; i < 400; i++) begin
         result_ready_in = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 63) == 0) begin
            flush_cycle();
         end else if ($urandom_range(0, 2) != 0) begin
            try_once(32'($urandom), 3'($urandom_range(0, 7)), ROB_IX'($urandom_range(0, 7)),
                     1'b0, 32'd0, 1'b0, acc);
         end else begin
            step();
         end
      end
      drain();

      // Asynchronous reset mid-transfer clears outputs before the next edge
      result_ready_in = 1'b0;
      issue(32'h500, 3'd2, 3'd1, 1'b0, 32'd0, 1'b0);
      issue(32'h504, 3'd2, 3'd2, 1'b0, 32'd0, 1'b0);
      step();
      step();
      @(negedge clk_in);
      check("pre_rst_valid", 32'(result_valid_out), 32'd1);
      req_valid_in = 1'b1;
      #2;
      rst_in = 1'b0;
      #1;
      check("async_rst_valid", 32'(result_valid_out), 32'd0);
      check("async_rst_read_out", 32'(req_read_out), 32'd0);
      check("async_rst_mem_en", 32'(mem_en_out), 32'd0);
      exp_q.delete();
      req_valid_in = 1'b0;
      step();
      rst_in = 1'b1;
      step();
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
